rca_seq_adder_ctrl: RTL and testbench
=====================================

// Module: rca_seq_adder_ctrl
// PURPOSE
//  Adds two WIDTH-bit operands by reusing one rca_4bit slice. Each clock it
//  processes one 4-bit nibble, least-significant nibble first, and carries
//  between nibbles through a register.
//  Operands arrive on a valid/ready input handshake; the result leaves on a
//  valid/ready output handshake. Trades latency for area in the datapath.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; must be a multiple of 4, >= 8
//  NSLICE  WIDTH/4 (localparam)  number of nibble passes per operation
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands A/B/Cin valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  A          in   WIDTH  operand A, sampled on input handshake
//  B          in   WIDTH  operand B, sampled on input handshake
//  Cin        in   1      carry-in, sampled on input handshake
//  out_valid  out  1      Sum/Cout valid
//  out_ready  in   1      consumer accepts result
//  Sum        out  WIDTH  (A+B+Cin) mod 2^WIDTH
//  Cout       out  1      bit WIDTH of A+B+Cin
//  busy       out  1      high in ADD or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, slice index=0, carry reg=0, operand regs=0.
//   - Sum=0, Cout=0, out_valid=0, busy=0, in_ready=1 (after reset release).
//  FSM states: IDLE -> ADD -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid & in_ready at edge E0: register A, B; carry reg<=Cin;
//     idx<=0; Sum<=0; go to ADD.
//  ADD:
//   - in_ready=0; in_valid is ignored.
//   - The rca_4bit instance gets A[4*idx+:4], B[4*idx+:4] and the carry reg.
//   - At each edge: Sum[4*idx+:4]<=slice sum; carry reg<=slice Cout; idx<=idx+1.
//   - At the edge where idx==NSLICE-1: Cout<=slice Cout, out_valid<=1, go to DONE.
//  Latency:
//   - out_valid goes high exactly NSLICE cycles after the input handshake edge.
//   - Back-to-back throughput is 1 operation per NSLICE+2 cycles.
//  DONE:
//   - out_valid=1; Sum/Cout held stable until accepted.
//   - On out_valid & out_ready at an edge: out_valid<=0, go to IDLE.
//   - in_ready rises the following cycle; there is no same-cycle bypass.
//  Sum and Cout:
//   - Registered outputs; they keep their value after handoff until the
//     next input handshake clears Sum.
//  Width rule: carry propagates only through the carry register; no combinational
//   path from A/B to Sum/Cout or from out_ready to in_ready.
//  Boundary cases:
//   - out_ready held low: remain in DONE indefinitely; outputs must not change.
//   - in_valid in ADD/DONE: no effect; operands are not re-sampled.
//   - Reset mid-ADD/DONE: immediate return to reset values; the partial
//     result is discarded.
//   - idx never exceeds NSLICE-1; it wraps to 0 only via the input handshake.
// TESTING (WIDTH=16)
//  1. 0x0000+0x0000, Cin=0 -> Sum=0x0000, Cout=0; out_valid exactly 4 cycles
//     after handshake.
//  2. 0xFFFF+0x0001, Cin=0 -> Sum=0x0000, Cout=1 (carry ripples through all
//     4 passes).
//  3. 0x1234+0x4321, Cin=1 -> Sum=0x5556, Cout=0; then 0x8000+0x8000, Cin=1
//     -> Sum=0x0001, Cout=1.
//  4. Hold out_ready=0 for 10 cycles with in_valid=1 and new operands ->
//     Sum/Cout stable, in_ready=0, out_valid=1; release -> IDLE, in_ready=1
//     next cycle.
//  5. Assert rst_n=0 two cycles into ADD -> Sum=0, Cout=0, out_valid=0,
//     busy=0 without waiting for a clock edge.
//  6. 1000 random A/B/Cin with random out_ready stalls -> every result equals
//     {Cout,Sum}==A+B+Cin.

Source files
------------

// File: rtl/rca_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder that reuses one 4-bit ripple-carry slice,
// one nibble per clock (LSB nibble first), with valid/ready on both sides.

module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    // Four chained full adders
    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module rca_seq_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy
);
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDXW   = $clog2(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [3:0]       slice_a, slice_b, slice_sum;
    logic             slice_cout;
    logic             load, step, last, accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)        state_nxt = ADD;
            ADD:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (out_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Control decode; depends on state and handshake inputs only, never on operands
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            ADD: begin
                busy = 1'b1;
                step = 1'b1;
                last = (idx == LAST_IDX);
            end
            DONE: begin
                busy   = 1'b1;
                accept = out_ready;
            end
            default: ;
        endcase
    end

    // Current nibble presented to the shared slice
    always_comb begin
        slice_a = a_reg[4*idx +: 4];
        slice_b = b_reg[4*idx +: 4];
    end

    rca_4bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Operand capture, nibble accumulation and result handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            a_reg <= A;
            b_reg <= B;
            carry <= Cin;
            idx   <= '0;
            Sum   <= '0;
        end else if (step) begin
            Sum[4*idx +: 4] <= slice_sum;
            carry           <= slice_cout;
            if (last) begin
                Cout      <= slice_cout;
                out_valid <= 1'b1;
            end else begin
                idx <= idx + IDXW'(1);
            end
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Randomized, self-checking bench for rca_seq_adder_ctrl (WIDTH=16) against
// a cycle-level arithmetic model plus directed literal cases.

module tb_rca_seq_adder_ctrl;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, Sum;
    logic         Cin, Cout, busy;

    int checks   = 0;
    int failures = 0;

    rca_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whole-word sum, Sum exposes the low 4*n bits after n passes
    logic         m_idle, m_valid, m_cout;
    int           m_cnt;
    logic [W:0]   m_res;
    logic [W-1:0] m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_valid = 1'b0; m_cnt = 0;
            m_res = '0; m_sum = '0; m_cout = 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_res  = (W+1)'(A) + (W+1)'(B) + (W+1)'(Cin);
                m_cnt  = 0;
                m_sum  = '0;
                m_idle = 1'b0;
            end
        end else if (!m_valid) begin
            m_cnt++;
            m_sum = m_res[W-1:0] & W'((32'd1 << (4 * m_cnt)) - 32'd1);
            if (m_cnt == NS) begin
                m_valid = 1'b1;
                m_cout  = m_res[W];
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  32'(in_ready),  32'(m_idle));
            chk("busy",      32'(busy),      32'(!m_idle));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("sum",       32'(Sum),       32'(m_sum));
            chk("cout",      32'(Cout),      32'(m_cout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One directed operation with literal expectations; caller ensures IDLE
    task automatic run_directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        in_valid = 1'b1; A = a; B = b; Cin = cin; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("dir_latency", 32'(lat), 32'(NS));
        chk("dir_sum",     32'(Sum), 32'(exp_sum));
        chk("dir_cout",    32'(Cout), 32'(exp_cout));
        tick();
        chk("dir_in_ready_after", 32'(in_ready), 32'd1);
        chk("dir_sum_kept",       32'(Sum), 32'(exp_sum));
    endtask

    logic [W:0] sb_q[$];

    initial begin
        int lat, ops, cyc;
        logic [W:0] exp_word;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #1;
        chk("rst_sum",       32'(Sum), 32'd0);
        chk("rst_cout",      32'(Cout), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_directed(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        run_directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_directed(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        run_directed(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

        // Stall in DONE while new operands are offered
        in_valid = 1'b1; A = 16'hABCD; B = 16'h1111; Cin = 1'b0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        chk("stall_latency", 32'(lat), 32'(NS));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            tick();
            chk("stall_sum",       32'(Sum), 32'h0000BCDE);
            chk("stall_cout",      32'(Cout), 32'd0);
            chk("stall_in_ready",  32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("release_in_ready",  32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // Leave Cout=1 behind, then reset two cycles into ADD
        run_directed(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        in_valid = 1'b1; A = 16'h7777; B = 16'h7777; Cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sum",       32'(Sum), 32'd0);
        chk("midrst_cout",      32'(Cout), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy), 32'd0);
        chk("midrst_in_ready",  32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Random traffic with random back-pressure and scoreboard on delivery
        ops = 0; cyc = 0;
        while ((ops < 1000 || sb_q.size() != 0) && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 9) < 7) && (ops < 1000);
            A         = W'($urandom);
            B         = W'($urandom);
            Cin       = 1'($urandom);
            out_ready = 1'($urandom);
            #1;
            if (in_valid && in_ready) begin
                sb_q.push_back((W+1)'(A) + (W+1)'(B) + (W+1)'(Cin));
                ops++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_word = sb_q.pop_front();
                    chk("sb_result", 32'({Cout, Sum}), 32'(exp_word));
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rand_ops_done",  32'(ops), 32'd1000);
        chk("rand_sb_drained", 32'(sb_q.size()), 32'd0);

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
